shift_sub_divide: RTL and testbench

Sequential unsigned restoring divider, the inverse companion of the shift-add multiplier in the same arithmetic lab datapath. It accepts a dividend/divisor pair on a `start` pulse and resolves one quotient bit per clock by shift-and-subtract. It reports quotient and remainder with a one-cycle `done` strobe, and flags division by zero.

---
 rtl/shift_sub_divide_if.sv | 36 +++
 rtl/shift_sub_divide.sv | 140 ++++++++++++++
 tb/tb_shift_sub_divide.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_sub_divide_if.sv
// Handshake and result bundle for the shift-subtract divider.
// The master drives the request side and the slave returns the results.
interface shift_sub_divide_if #(
    parameter int unsigned WIDTH = 31
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );
endinterface

// File: rtl/shift_sub_divide.sv
// Sequential unsigned restoring divider: one quotient bit per clock by shift-and-subtract,
// with a one-cycle done strobe and a divide-by-zero flag.
module shift_sub_divide #(
    parameter int unsigned WIDTH = 31
) (
    input logic               clk,
    input logic               rst_n,
    shift_sub_divide_if.slave div_io
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             dbz_pend_q, dbz_pend_d;

    logic             busy;
    logic             accept;
    logic             last_iter;
    logic             zero_div;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign zero_div = (div_io.divisor == '0);

    // The partial remainder after a step is always below the divisor, so its WIDTH+1'th
    // bit is always 0 and only the low WIDTH bits are stored; the compare stays WIDTH+1 wide.
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign fits     = (trial >= {1'b0, dvsr_q});
    assign diff     = trial[WIDTH-1:0] - dvsr_q;
    assign rem_next = fits ? diff : trial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && !zero_div) state_d = StRun;
            StRun:  if (last_iter) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StRun);
        accept    = (state_q == StIdle) && div_io.start;
        last_iter = (state_q == StRun) && (cnt_q == CntW'(1));
    end

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        dbz_pend_d  = 1'b0;

        // A zero divisor parks the dividend in quo_q and reports one edge later.
        if (dbz_pend_q) begin
            quotient_d  = '1;
            remainder_d = quo_q;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
        end

        if (accept) begin
            quo_d = div_io.dividend;
            if (zero_div) begin
                dbz_pend_d = 1'b1;
            end else begin
                rem_d  = '0;
                dvsr_d = div_io.divisor;
                cnt_d  = CntW'(WIDTH);
            end
        end

        if (busy) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q - CntW'(1);
            if (last_iter) begin
                quotient_d  = quo_next;
                remainder_d = rem_next;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            dbz_pend_q  <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            dbz_pend_q  <= dbz_pend_d;
        end
    end

    assign div_io.quotient    = quotient_q;
    assign div_io.remainder   = remainder_q;
    assign div_io.busy        = busy;
    assign div_io.done        = done_q;
    assign div_io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_divide.sv
// Directed bench for shift_sub_divide: an arithmetic model (a/b, a%b, timing windows)
// is compared against the DUT every cycle, plus hand-computed literal results.
module tb_shift_sub_divide;
    localparam int unsigned W = 31;
    localparam int Ones = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    shift_sub_divide_if #(.WIDTH(W)) bus ();

    shift_sub_divide #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_io (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: results are computed with plain division and scheduled for their done edge.
    typedef struct {
        int done_at;
        int q;
        int r;
        int dbz;
    } res_t;

    res_t pend[$];
    int   cyc = 0;
    int   run_start = 0;
    int   run_end = -1;
    int   m_done = 0;
    int   m_busy = 0;
    int   h_q = 0;
    int   h_r = 0;
    int   h_dbz = 0;
    int   m_a, m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            run_start = 0;
            run_end   = -1;
            m_done    = 0;
            m_busy    = 0;
            h_q       = 0;
            h_r       = 0;
            h_dbz     = 0;
        end else begin
            cyc++;
            m_done = 0;
            if (pend.size() > 0 && pend[0].done_at == cyc) begin
                h_q    = pend[0].q;
                h_r    = pend[0].r;
                h_dbz  = pend[0].dbz;
                m_done = 1;
                void'(pend.pop_front());
            end
            if (bus.start && cyc > run_end) begin
                m_a = int'(bus.dividend);
                m_b = int'(bus.divisor);
                if (m_b != 0) begin
                    run_start = cyc;
                    run_end   = cyc + W;
                    pend.push_back('{done_at: cyc + W, q: m_a / m_b, r: m_a % m_b, dbz: 0});
                end else begin
                    pend.push_back('{done_at: cyc + 1, q: Ones, r: m_a, dbz: 1});
                end
            end
            m_busy = (cyc >= run_start && cyc < run_end) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_done", int'(bus.done), m_done);
        chk("cyc_busy", int'(bus.busy), m_busy);
        chk("cyc_quotient", int'(bus.quotient), h_q);
        chk("cyc_remainder", int'(bus.remainder), h_r);
        chk("cyc_div_by_zero", int'(bus.div_by_zero), h_dbz);
    end

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic do_start(input int a, input int b, output int e);
        bus.start    = 1'b1;
        bus.dividend = a[W-1:0];
        bus.divisor  = b[W-1:0];
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 31'($urandom);
        bus.divisor  = 31'($urandom);
        e = cyc;
    endtask

    task automatic wait_done(input int e, output int lat, output int busy_n);
        busy_n = 0;
        lat    = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat = cyc - e;
                break;
            end
            if (bus.busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input int q, input int r, input int dbz,
                                input int lat, input int exp_lat);
        chk({name, "_quotient"}, int'(bus.quotient), q);
        chk({name, "_remainder"}, int'(bus.remainder), r);
        chk({name, "_div_by_zero"}, int'(bus.div_by_zero), dbz);
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int e, lat, busy_n, d1, cnt;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_div_by_zero", int'(bus.div_by_zero), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_start(64, 8, e);
        wait_done(e, lat, busy_n);
        check_result("64div8", 8, 0, 0, lat, 31);
        chk("64div8_busy_cycles", busy_n, 31);

        do_start(100, 7, e);
        wait_done(e, lat, busy_n);
        check_result("100div7", 14, 2, 0, lat, 31);
        d1 = cyc;
        do_start(5, 9, e);
        wait_done(e, lat, busy_n);
        check_result("5div9", 0, 5, 0, lat, 31);
        chk("b2b_done_spacing", cyc - d1, 32);

        do_start(32'h7FFF_FFFF, 1, e);
        wait_done(e, lat, busy_n);
        check_result("max_div1", 32'h7FFF_FFFF, 0, 0, lat, 31);
        do_start(32'h7FFF_FFFF, 32'h7FFF_FFFF, e);
        wait_done(e, lat, busy_n);
        check_result("max_divmax", 1, 0, 0, lat, 31);

        do_start(123, 0, e);
        wait_done(e, lat, busy_n);
        check_result("123div0", 32'h7FFF_FFFF, 123, 1, lat, 1);
        chk("123div0_busy_cycles", busy_n, 0);
        do_start(10, 3, e);
        wait_done(e, lat, busy_n);
        check_result("10div3", 3, 1, 0, lat, 31);

        do_start(1000, 10, e);
        repeat (9) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 31'd9;
        bus.divisor  = 31'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(e, lat, busy_n);
        check_result("1000div10", 100, 0, 0, lat, 31);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("ignored_start_extra_done", cnt, 0);

        do_start(77, 5, e);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_quotient", int'(bus.quotient), 0);
        chk("midrst_remainder", int'(bus.remainder), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_div_by_zero", int'(bus.div_by_zero), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("aborted_op_done", cnt, 0);
        do_start(77, 5, e);
        wait_done(e, lat, busy_n);
        check_result("77div5", 15, 2, 0, lat, 31);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
